// File: rtl/mips_mc_core_if.sv
// mips_mc_core_if: shared instruction/data memory port of the multi-cycle core.
// Handshake: the master raises mem_req with mem_addr, mem_we and mem_wdata, and
// keeps all four stable until it samples mem_ready=1 at a rising clk edge. That
// edge completes the transfer, and mem_rdata is valid in that same cycle.
// mem_ready is ignored while mem_req=0.
interface mips_mc_core_if #(
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS subset core with one shared ALU, one register
// file and one request/ready memory port for both fetch and data access.
// Optional feature macro: MC_BADOP_TRAP_EN. When it is defined, an unsupported
// instruction halts the core in DECODE. Otherwise it runs as a 3-cycle NOP.
// dbg_state exposes the FSM state encoding for checkers.
module mips_mc_core #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    mips_mc_core_if.master    bus,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    input  logic [4:0]        dbg_ra,
    output logic [31:0]       dbg_rd,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state, next_state;
    logic [31:0]       ir, a, b, alu_out, alu_res;
    logic [31:0]       gpr [32];
    logic [ADDR_W-1:0] pc4, br_tgt, j_tgt;
    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, shamt, wb_idx;
    logic [31:0]       imm_s, imm_z, wb_val;
    logic              r_alu, i_alu, is_jr, is_sys, is_j, is_jal, is_beq, is_bne;
    logic              is_lw, is_sw, is_alu, is_valid, trap_bad;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];
    assign imm_s = {{16{ir[15]}}, ir[15:0]};
    assign imm_z = {16'h0000, ir[15:0]};

    assign is_alu   = r_alu | i_alu;
    assign is_valid = is_alu | is_jr | is_sys | is_j | is_jal | is_beq | is_bne | is_lw | is_sw;
`ifdef MC_BADOP_TRAP_EN
    assign trap_bad = ~is_valid;
`else
    assign trap_bad = 1'b0;
`endif

    // The branch offset is relative to pc+4. The jump keeps the pc+4 bits above bit 27, when ADDR_W has any.
    assign br_tgt = pc4 + ADDR_W'({imm_s[29:0], 2'b00});
    assign j_tgt  = (pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({ir[25:0], 2'b00});

    assign wb_idx = is_jal ? 5'd31 : ((op == 6'h00) ? rd : rt);
    assign wb_val = is_jal ? 32'(pc4) : alu_out;

    assign dbg_rd    = (dbg_ra == 5'd0) ? 32'd0 : gpr[dbg_ra];
    assign dbg_state = state;

    // Classify the latched instruction.
    always_comb begin
        r_alu  = 1'b0; i_alu  = 1'b0; is_jr  = 1'b0; is_sys = 1'b0;
        is_j   = 1'b0; is_jal = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
        is_lw  = 1'b0; is_sw  = 1'b0;
        if (op == 6'h00) begin
            case (funct)
                6'h00, 6'h02, 6'h03, 6'h21, 6'h23, 6'h24,
                6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: r_alu  = 1'b1;
                6'h08:                             is_jr  = 1'b1;
                6'h0C:                             is_sys = 1'b1;
                default:                           ;
            endcase
        end else begin
            case (op)
                6'h02:                                     is_j   = 1'b1;
                6'h03:                                     is_jal = 1'b1;
                6'h04:                                     is_beq = 1'b1;
                6'h05:                                     is_bne = 1'b1;
                6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: i_alu  = 1'b1;
                6'h23:                                     is_lw  = 1'b1;
                6'h2B:                                     is_sw  = 1'b1;
                default:                                   ;
            endcase
        end
    end

    // Shared ALU. The default sum is also the lw/sw effective address.
    always_comb begin
        alu_res = a + imm_s;
        if (op == 6'h00) begin
            case (funct)
                6'h00:   alu_res = b << shamt;
                6'h02:   alu_res = b >> shamt;
                6'h03:   alu_res = $signed(b) >>> shamt;
                6'h21:   alu_res = a + b;
                6'h23:   alu_res = a - b;
                6'h24:   alu_res = a & b;
                6'h25:   alu_res = a | b;
                6'h26:   alu_res = a ^ b;
                6'h27:   alu_res = ~(a | b);
                6'h2A:   alu_res = {31'd0, $signed(a) < $signed(b)};
                6'h2B:   alu_res = {31'd0, a < b};
                default: alu_res = '0;
            endcase
        end else begin
            case (op)
                6'h0A:   alu_res = {31'd0, $signed(a) < $signed(imm_s)};
                6'h0C:   alu_res = a & imm_z;
                6'h0D:   alu_res = a | imm_z;
                6'h0E:   alu_res = a ^ imm_z;
                6'h0F:   alu_res = {ir[15:0], 16'h0000};
                default: alu_res = a + imm_s;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next state, memory request and status strobes.
    always_comb begin
        next_state    = state;
        retire        = 1'b0;
        halted        = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = pc;
        bus.mem_wdata = '0;
        case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) next_state = S_DECODE;
            end
            S_DECODE: next_state = (is_sys || trap_bad) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    next_state = S_MEM;
                end else if (is_alu || is_jal) begin
                    next_state = S_WB;
                end else begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MEM: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = {alu_out[ADDR_W-1:2], 2'b00};
                bus.mem_we    = is_sw;
                bus.mem_wdata = is_sw ? b : 32'd0;
                if (bus.mem_ready) begin
                    retire     = is_sw;
                    next_state = is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: next_state = S_FETCH;
        endcase
    end

    // Datapath registers, the PC and the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            pc4     <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (bus.mem_ready) ir <= bus.mem_rdata;
                S_DECODE: begin
                    a   <= (rs == 5'd0) ? 32'd0 : gpr[rs];
                    b   <= (rt == 5'd0) ? 32'd0 : gpr[rt];
                    pc4 <= pc + ADDR_W'(4);
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (is_beq)              pc <= (a == b) ? br_tgt : pc4;
                    else if (is_bne)         pc <= (a != b) ? br_tgt : pc4;
                    else if (is_j || is_jal) pc <= j_tgt;
                    else if (is_jr)          pc <= {a[ADDR_W-1:2], 2'b00};
                    else if (!is_valid)      pc <= pc4;
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (is_sw) pc      <= pc4;
                        else       alu_out <= bus.mem_rdata;
                    end
                end
                S_WB: begin
                    if (wb_idx != 5'd0) gpr[wb_idx] <= wb_val;
                    if (!is_jal)        pc          <= pc4;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mc_core.sv
// tb_mips_mc_core: directed bench for mips_mc_core. It uses a 12-bit core backed
// by a word-array memory with programmable wait states, and an 8-bit core that
// exercises PC wrap at the top of the address space.
module tb_mips_mc_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  dbg_ra = 5'd0;
    logic [11:0] pc;
    logic        retire, halted;
    logic [31:0] dbg_rd;
    logic [2:0]  dbg_state;
    logic [7:0]  pc2;
    logic        retire2, halted2;
    logic [31:0] dbg_rd2;
    logic [2:0]  dbg_state2;

    int checks = 0;
    int errors = 0;
    int waits = 0;
    int wcnt = 0;
    int retire_cnt = 0;

    logic [31:0] mem_arr [0:1023];

    logic        hold_valid = 1'b0, hold_req = 1'b0, hold_rdy = 1'b0, hold_we = 1'b0;
    logic [11:0] hold_addr = '0;
    logic [31:0] hold_wdata = '0;

    localparam logic [31:0] SYSCALL = 32'h0000_000C;

    mips_mc_core_if #(.ADDR_W(12)) bus ();
    mips_mc_core_if #(.ADDR_W(8))  bus2 ();

    mips_mc_core #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clk(clk), .reset(reset), .bus(bus), .pc(pc), .retire(retire),
        .halted(halted), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .dbg_state(dbg_state)
    );

    mips_mc_core #(.ADDR_W(8), .RESET_PC(8'hFC)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .pc(pc2), .retire(retire2),
        .halted(halted2), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd2), .dbg_state(dbg_state2)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory responder: ready rises after `waits` stalled cycles of a request.
    assign bus.mem_rdata  = mem_arr[bus.mem_addr[11:2]];
    assign bus.mem_ready  = (wcnt >= waits);
    assign bus2.mem_rdata = 32'h0000_0021;
    assign bus2.mem_ready = 1'b1;

    always @(posedge clk) begin
        if (reset || !bus.mem_req || bus.mem_ready) wcnt <= 0;
        else                                       wcnt <= wcnt + 1;
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] instr;
        logic [4:0]  dst;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] r_op(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_op(int op, int rs, int rt, logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One cycle. Sampled at negedge: store commit, request-hold check and retire count.
    task automatic tick();
        @(negedge clk);
        if (bus.mem_req && bus.mem_ready && bus.mem_we)
            mem_arr[bus.mem_addr[11:2]] = bus.mem_wdata;
        if (hold_valid && hold_req && !hold_rdy) begin
            checks++;
            if (!(bus.mem_req === 1'b1 && bus.mem_addr === hold_addr &&
                  bus.mem_we === hold_we && bus.mem_wdata === hold_wdata)) begin
                errors++;
                $display("FAIL req_hold: got req=%b addr=0x%03h we=%b wdata=0x%08h expected req=1 addr=0x%03h we=%b wdata=0x%08h",
                         bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata, hold_addr, hold_we, hold_wdata);
            end
        end
        hold_valid = 1'b1;
        hold_req   = bus.mem_req;
        hold_rdy   = bus.mem_ready;
        hold_addr  = bus.mem_addr;
        hold_we    = bus.mem_we;
        hold_wdata = bus.mem_wdata;
        if (retire) retire_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold_valid = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'd0;
    endtask

    task automatic put(int addr, logic [31:0] w);
        mem_arr[addr / 4] = w;
    endtask

    // Cycles up to and including the next retire pulse.
    task automatic wait_retire(output int n);
        int got;
        got = 0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (retire) begin
                got = 1;
                break;
            end
        end
        if (got == 0) begin
            checks++;
            errors++;
            $display("FAIL retire_timeout: got no retire expected retire within 100 cycles");
        end
    endtask

    task automatic wait_halt(string name);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (halted) break;
        end
        check(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic check_pc_after(string name, logic [11:0] exp);
        @(posedge clk);
        #1;
        check(name, {20'd0, pc}, {20'd0, exp});
    endtask

    task automatic check_reg(string name, logic [4:0] r, logic [31:0] exp);
        dbg_ra = r;
        #1;
        check(name, dbg_rd, exp);
    endtask

    initial begin : safety
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, base, found;
        logic [31:0] orv;

        vecs.push_back('{"addu",  32'd5,          32'd7,          r_op(1, 2, 3, 0, 'h21),    5'd3, 32'd12});
        vecs.push_back('{"subu",  32'd3,          32'd5,          r_op(1, 2, 3, 0, 'h23),    5'd3, 32'hFFFF_FFFE});
        vecs.push_back('{"and",   32'hF0F0_1234, 32'hFF00_FF00, r_op(1, 2, 3, 0, 'h24),    5'd3, 32'hF000_1200});
        vecs.push_back('{"or",    32'hF0F0_1234, 32'hFF00_FF00, r_op(1, 2, 3, 0, 'h25),    5'd3, 32'hFFF0_FF34});
        vecs.push_back('{"xor",   32'hF0F0_1234, 32'hFF00_FF00, r_op(1, 2, 3, 0, 'h26),    5'd3, 32'h0FF0_ED34});
        vecs.push_back('{"nor",   32'hF0F0_1234, 32'hFF00_FF00, r_op(1, 2, 3, 0, 'h27),    5'd3, 32'h000F_00CB});
        vecs.push_back('{"slt",   32'h8000_0000, 32'd1,          r_op(1, 2, 3, 0, 'h2A),    5'd3, 32'd1});
        vecs.push_back('{"sltu",  32'h8000_0000, 32'd1,          r_op(1, 2, 3, 0, 'h2B),    5'd3, 32'd0});
        vecs.push_back('{"sll",   32'd0,          32'h8000_0001, r_op(0, 2, 3, 4, 'h00),    5'd3, 32'h0000_0010});
        vecs.push_back('{"srl",   32'd0,          32'h8000_0010, r_op(0, 2, 3, 4, 'h02),    5'd3, 32'h0800_0001});
        vecs.push_back('{"sra",   32'd0,          32'h8000_0010, r_op(0, 2, 3, 4, 'h03),    5'd3, 32'hF800_0001});
        vecs.push_back('{"addiu", 32'd0,          32'd0,          i_op('h09, 1, 3, 16'hFFFF), 5'd3, 32'hFFFF_FFFF});
        vecs.push_back('{"slti",  32'h8000_0000, 32'd0,          i_op('h0A, 1, 3, 16'hFFFF), 5'd3, 32'd1});
        vecs.push_back('{"andi",  32'hFFFF_1234, 32'd0,          i_op('h0C, 1, 3, 16'hFFFF), 5'd3, 32'h0000_1234});
        vecs.push_back('{"ori",   32'h0001_0000, 32'd0,          i_op('h0D, 1, 3, 16'h8000), 5'd3, 32'h0001_8000});
        vecs.push_back('{"xori",  32'h0000_F0F0, 32'd0,          i_op('h0E, 1, 3, 16'hFFFF), 5'd3, 32'h0000_0F0F});
        vecs.push_back('{"lui",   32'd0,          32'd0,          i_op('h0F, 0, 3, 16'h8001), 5'd3, 32'h8001_0000});
        vecs.push_back('{"zero",  32'd0,          32'd0,          i_op('h09, 0, 0, 16'h0007), 5'd0, 32'd0});

        // Reset state and the basic ALU sequence.
        waits = 0;
        clear_mem();
        put(0,  i_op('h0D, 0, 1, 16'd5));
        put(4,  r_op(1, 1, 2, 0, 'h21));
        put(8,  r_op(0, 2, 3, 2, 'h00));
        put(12, SYSCALL);
        do_reset();
        base = retire_cnt;
        tick();
        check("rst_req",    {31'd0, bus.mem_req},  32'd1);
        check("rst_addr",   {20'd0, bus.mem_addr}, 32'd0);
        check("rst_we",     {31'd0, bus.mem_we},   32'd0);
        check("rst_wdata",  bus.mem_wdata,         32'd0);
        check("rst_retire", {31'd0, retire},       32'd0);
        check("rst_halted", {31'd0, halted},       32'd0);
        check("rst_pc",     {20'd0, pc},           32'd0);
        wait_halt("seq_halt");
        check_reg("seq_r3", 5'd3, 32'd40);
        check("seq_retires", retire_cnt - base, 32'd3);
        for (int i = 0; i < 5; i++) tick();
        check("halt_noreq", {31'd0, bus.mem_req}, 32'd0);
        check("halt_stay",  {31'd0, halted},      32'd1);
        check("halt_retires", retire_cnt - base,  32'd3);

        // Table of single-instruction ALU vectors.
        foreach (vecs[v]) begin
            clear_mem();
            put(0,  i_op('h0F, 0, 1, vecs[v].a[31:16]));
            put(4,  i_op('h0D, 1, 1, vecs[v].a[15:0]));
            put(8,  i_op('h0F, 0, 2, vecs[v].b[31:16]));
            put(12, i_op('h0D, 2, 2, vecs[v].b[15:0]));
            put(16, vecs[v].instr);
            put(20, SYSCALL);
            do_reset();
            for (int k = 0; k < 4; k++) wait_retire(n);
            wait_retire(n);
            check({vecs[v].name, "_cyc"}, n, 32'd4);
            wait_halt({vecs[v].name, "_halt"});
            check_reg(vecs[v].name, vecs[v].dst, vecs[v].exp);
        end

        // Store then load with two wait cycles per request.
        waits = 2;
        clear_mem();
        put(0,    i_op('h0D, 0, 1, 16'd5));
        put(4,    {6'h02, 26'h10});
        put(8,    32'hFFFF_FFFF);
        put(12'h40, i_op('h2B, 0, 1, 16'd8));
        put(12'h44, i_op('h23, 0, 4, 16'd8));
        put(12'h48, SYSCALL);
        do_reset();
        wait_retire(n);
        check("ori_wait_cyc", n, 32'd6);
        wait_retire(n);
        check("j_wait_cyc", n, 32'd5);
        wait_retire(n);
        check("sw_wait_cyc", n, 32'd8);
        check("sw_data", mem_arr[2], 32'd5);
        wait_retire(n);
        check("lw_wait_cyc", n, 32'd9);
        wait_halt("mem_halt");
        check_reg("lw_r4", 5'd4, 32'd5);

        // Control flow: bne not taken, jal, jr.
        waits = 0;
        clear_mem();
        put(0,    i_op('h0D, 0, 1, 16'd7));
        put(4,    i_op('h05, 1, 1, 16'd5));
        put(8,    {6'h03, 26'h8});
        put(12,   i_op('h0D, 0, 5, 16'h55));
        put(16,   SYSCALL);
        put(12'h20, i_op('h0D, 0, 6, 16'h66));
        put(12'h24, r_op(31, 0, 0, 0, 'h08));
        do_reset();
        wait_retire(n);
        wait_retire(n);
        check("bne_cyc", n, 32'd3);
        check_pc_after("bne_pc", 12'h008);
        wait_retire(n);
        check("jal_cyc", n, 32'd4);
        check_pc_after("jal_pc", 12'h020);
        wait_retire(n);
        wait_retire(n);
        check("jr_cyc", n, 32'd3);
        check_pc_after("jr_pc", 12'h00C);
        wait_halt("ctl_halt");
        check_reg("jal_r31", 5'd31, 32'h0000_000C);
        check_reg("ret_r5",  5'd5,  32'h0000_0055);
        check_reg("sub_r6",  5'd6,  32'h0000_0066);

        // beq with offset -1 spins on its own address.
        clear_mem();
        put(0, 32'h1000_FFFF);
        do_reset();
        wait_retire(n);
        check("beq_cyc0", n, 32'd3);
        check_pc_after("beq_pc0", 12'h000);
        wait_retire(n);
        check("beq_cyc1", n, 32'd3);
        check_pc_after("beq_pc1", 12'h000);

        // Reset while a lw is stalled in MEM.
        waits = 4;
        clear_mem();
        put(0,    i_op('h0D, 0, 1, 16'd9));
        put(4,    i_op('h23, 0, 4, 16'h30));
        put(12'h30, 32'hDEAD_BEEF);
        do_reset();
        wait_retire(n);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.mem_req && bus.mem_addr == 12'h030 && !bus.mem_ready) begin
                found = 1;
                break;
            end
        end
        check("lw_stall_seen", found, 32'd1);
        do_reset();
        tick();
        check("mrst_pc",   {20'd0, pc},           32'd0);
        check("mrst_we",   {31'd0, bus.mem_we},   32'd0);
        check("mrst_req",  {31'd0, bus.mem_req},  32'd1);
        check("mrst_addr", {20'd0, bus.mem_addr}, 32'd0);
        orv = 32'd0;
        for (int r = 0; r < 32; r++) begin
            dbg_ra = 5'(r);
            #1;
            orv = orv | dbg_rd;
        end
        check("mrst_gprs", orv, 32'd0);

        // Unsupported opcode 0x3F.
        waits = 0;
        clear_mem();
        put(0, 32'hFC00_0000);
        put(4, SYSCALL);
        do_reset();
        base = retire_cnt;
`ifdef MC_BADOP_TRAP_EN
        wait_halt("badop_halt");
        check("badop_noretire", retire_cnt - base, 32'd0);
        check("badop_pc", {20'd0, pc}, 32'd0);
`else
        wait_retire(n);
        check("badop_cyc", n, 32'd3);
        check_pc_after("badop_pc", 12'h004);
        wait_halt("badop_halt");
        check("badop_retires", retire_cnt - base, 32'd1);
`endif

        // 8-bit core starting at 0xFC: the next fetch wraps to 0x00.
        clear_mem();
        put(0, SYSCALL);
        do_reset();
        @(negedge clk);
        check("wrap_first_addr", {24'd0, bus2.mem_addr}, 32'h0000_00FC);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (retire2) break;
            @(negedge clk);
            n++;
        end
        check("wrap_cyc", n, 32'd4);
        @(posedge clk);
        #1;
        check("wrap_pc", {24'd0, pc2}, 32'd0);
        @(negedge clk);
        check("wrap_fetch", {23'd0, bus2.mem_req, bus2.mem_addr}, 32'h0000_0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
